// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU register-file sequencer: widths, function codes
// and FSM state encoding.
package alu_seq_pkg;

  localparam int DATA_W = 4;
  localparam int REG_N  = 4;
  localparam int ADDR_W = 2;
  localparam int FUNC_W = 3;

  localparam logic [FUNC_W-1:0] F_AND     = 3'b000;
  localparam logic [FUNC_W-1:0] F_OR      = 3'b001;
  localparam logic [FUNC_W-1:0] F_ADD     = 3'b010;
  localparam logic [FUNC_W-1:0] F_ILLEGAL = 3'b011;
  localparam logic [FUNC_W-1:0] F_ANDN    = 3'b100;
  localparam logic [FUNC_W-1:0] F_ORN     = 3'b101;
  localparam logic [FUNC_W-1:0] F_SUB     = 3'b110;
  localparam logic [FUNC_W-1:0] F_SLT     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_illegal(input logic [FUNC_W-1:0] f);
    return f == F_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, ALU and result signals of the sequencer. res_zero exists only when
// ALU_SEQ_ZERO_FLAG_EN is defined.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// the source holds its payload stable while valid is high and ready is low.
interface alu_sequencer_if;
  import alu_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [FUNC_W-1:0] cmd_f;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [FUNC_W-1:0] alu_f;
  logic [DATA_W-1:0] alu_y;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic              res_zero;
`endif

  modport slave (
    input  cmd_valid, cmd_f, cmd_rd, cmd_rs1, cmd_rs2, alu_y, res_ready,
    output cmd_ready, alu_a, alu_b, alu_f, res_valid, res_data, res_err
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , output res_zero
`endif
  );

  modport master (
    output cmd_valid, cmd_f, cmd_rd, cmd_rs1, cmd_rs2, alu_y, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_f, res_valid, res_data, res_err
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , input res_zero
`endif
  );

endinterface

// File: rtl/alu_seq_regfile.sv
// 4x4-bit register file: two asynchronous read ports, one synchronous write port,
// synchronous clear of every register.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [REG_N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

endmodule

// File: rtl/alu_sequencer.sv
// Register-file front end for an external 4-bit ALU: IDLE -> EXEC -> RESP per command.
// Optional res_zero flag enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus,
  output state_e         dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [FUNC_W-1:0] f_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  logic              rf_we;

  // Writeback happens exactly once, on the EXEC edge, and only for legal codes.
  assign rf_we = (state == EXEC) && !is_illegal(f_q);

  alu_seq_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .wa    (rd_q),
    .wd    (bus.alu_y),
    .ra1   (bus.cmd_rs1),
    .rd1   (rf_rd1),
    .ra2   (bus.cmd_rs2),
    .rd2   (rf_rd2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rd_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      f_q    <= F_AND;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            rd_q  <= bus.cmd_rd;
            a_q   <= rf_rd1;
            b_q   <= rf_rd2;
            f_q   <= bus.cmd_f;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (is_illegal(f_q)) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end else begin
            data_q <= bus.alu_y;
            err_q  <= 1'b0;
          end
          state <= RESP;
        end
        RESP: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
    end else if (state == EXEC) begin
      zero_q <= !is_illegal(f_q) && (bus.alu_y == '0);
    end
  end

  assign bus.res_zero = zero_q;
`endif

  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = (state == RESP);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_f     = f_q;
  assign bus.res_data  = data_q;
  assign bus.res_err   = err_q;
  assign dbg_state     = state_e'(state);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU on the alu_* ports.
// Zero-flag checks are compiled in when ALU_SEQ_ZERO_FLAG_EN is defined.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic   clk;
  logic   reset;
  state_e dbg_state;
  int     checks;
  int     errors;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] f);
    case (f)
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_ADD:   return a + b;
      F_ANDN:  return a & ~b;
      F_ORN:   return a | ~b;
      F_SUB:   return a - b;
      F_SLT:   return (a < b) ? 4'd1 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  always_comb bus.alu_y = alu_fn(bus.alu_a, bus.alu_b, bus.alu_f);

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a command and return #1 after the edge that accepted it.
  task automatic send(input string tag, input logic [2:0] f, input logic [1:0] rd,
                      input logic [1:0] rs1, input logic [1:0] rs2);
    int n;
    @(negedge clk);
    bus.cmd_f     = f;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, {3'b0, bus.cmd_ready}, 4'h1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check({tag, "_rv_drop"}, {3'b0, bus.res_valid}, 4'h0);
    check({tag, "_cr_back"}, {3'b0, bus.cmd_ready}, 4'h1);
  endtask

  task automatic check_result(input string tag, input logic [3:0] ed, input logic ee);
    check({tag, "_rvalid"}, {3'b0, bus.res_valid}, 4'h1);
    check({tag, "_data"}, bus.res_data, ed);
    check({tag, "_err"}, {3'b0, bus.res_err}, {3'b0, ee});
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check({tag, "_zero"}, {3'b0, bus.res_zero}, {3'b0, (!ee && ed == 4'h0)});
`endif
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] f, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [3:0] ea, input logic [3:0] eb,
                         input logic [3:0] ed, input logic ee);
    send(tag, f, rd, rs1, rs2);
    check({tag, "_alu_a"}, bus.alu_a, ea);
    check({tag, "_alu_b"}, bus.alu_b, eb);
    check({tag, "_alu_f"}, {1'b0, bus.alu_f}, {1'b0, f});
    check({tag, "_exec"}, {2'b0, dbg_state}, {2'b0, ST_EXEC});
    check({tag, "_cr_low"}, {3'b0, bus.cmd_ready}, 4'h0);
    @(posedge clk);
    #1;
    check_result(tag, ed, ee);
    release_result(tag);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_f     = '0;
    bus.cmd_rd    = '0;
    bus.cmd_rs1   = '0;
    bus.cmd_rs2   = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_cmd_ready", {3'b0, bus.cmd_ready}, 4'h1);
    check("rst_res_valid", {3'b0, bus.res_valid}, 4'h0);
    check("rst_res_data", bus.res_data, 4'h0);
    check("rst_res_err", {3'b0, bus.res_err}, 4'h0);
    check("rst_alu_a", bus.alu_a, 4'h0);
    check("rst_alu_b", bus.alu_b, 4'h0);
    check("rst_alu_f", {1'b0, bus.alu_f}, 4'h0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("rst_res_zero", {3'b0, bus.res_zero}, 4'h0);
`endif

    // res_ready while nothing pending must not disturb IDLE.
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("idle_rr_ignored", {2'b0, dbg_state}, {2'b0, ST_IDLE});

    run_cmd("add0",   F_ADD,     2'd0, 2'd1, 2'd2, 4'h0, 4'h0, 4'h0, 1'b0);
    run_cmd("orn_r1", F_ORN,     2'd1, 2'd0, 2'd0, 4'h0, 4'h0, 4'hF, 1'b0);
    run_cmd("sub_r2", F_SUB,     2'd2, 2'd0, 2'd1, 4'h0, 4'hF, 4'h1, 1'b0);
    run_cmd("add_wr", F_ADD,     2'd3, 2'd1, 2'd2, 4'hF, 4'h1, 4'h0, 1'b0);
    run_cmd("slt_t",  F_SLT,     2'd0, 2'd2, 2'd1, 4'h1, 4'hF, 4'h1, 1'b0);
    run_cmd("slt_f",  F_SLT,     2'd0, 2'd1, 2'd2, 4'hF, 4'h1, 4'h0, 1'b0);
    run_cmd("illeg",  F_ILLEGAL, 2'd1, 2'd2, 2'd2, 4'h1, 4'h1, 4'h0, 1'b1);
    run_cmd("or_r1",  F_OR,      2'd0, 2'd1, 2'd1, 4'hF, 4'hF, 4'hF, 1'b0);
    run_cmd("and",    F_AND,     2'd0, 2'd1, 2'd2, 4'hF, 4'h1, 4'h1, 1'b0);
    run_cmd("andn",   F_ANDN,    2'd0, 2'd1, 2'd2, 4'hF, 4'h1, 4'hE, 1'b0);
    run_cmd("same",   F_ADD,     2'd2, 2'd2, 2'd2, 4'h1, 4'h1, 4'h2, 1'b0);
    run_cmd("rd_r2",  F_OR,      2'd0, 2'd2, 2'd2, 4'h2, 4'h2, 4'h2, 1'b0);

    // Backpressure: result held while a second command waits on cmd_valid.
    send("hold", F_AND, 2'd0, 2'd1, 2'd1);
    @(posedge clk);
    #1;
    check_result("hold0", 4'hF, 1'b0);
    bus.cmd_f     = F_SUB;
    bus.cmd_rd    = 2'd0;
    bus.cmd_rs1   = 2'd1;
    bus.cmd_rs2   = 2'd2;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_rvalid", {3'b0, bus.res_valid}, 4'h1);
      check("hold_data", bus.res_data, 4'hF);
      check("hold_cr_low", {3'b0, bus.cmd_ready}, 4'h0);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("hold_rel_cr", {3'b0, bus.cmd_ready}, 4'h1);
    check("hold_rel_rv", {3'b0, bus.res_valid}, 4'h0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("hold_acc2", {2'b0, dbg_state}, {2'b0, ST_EXEC});
    check("hold_acc2_a", bus.alu_a, 4'hF);
    check("hold_acc2_b", bus.alu_b, 4'h2);
    @(posedge clk);
    #1;
    check_result("hold2", 4'hD, 1'b0);
    release_result("hold2");
    repeat (2) @(posedge clk);
    #1;
    check("hold_no_extra", {2'b0, dbg_state}, {2'b0, ST_IDLE});

    // Reset while a SUB into r3 sits in EXEC: no writeback, everything cleared.
    send("rst_exec", F_SUB, 2'd3, 2'd2, 2'd1);
    check("rst_exec_state", {2'b0, dbg_state}, {2'b0, ST_EXEC});
    check("rst_exec_a", bus.alu_a, 4'h2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mid_rvalid", {3'b0, bus.res_valid}, 4'h0);
    check("rst_mid_cready", {3'b0, bus.cmd_ready}, 4'h1);
    check("rst_mid_alu_a", bus.alu_a, 4'h0);
    run_cmd("r3_clear", F_OR, 2'd0, 2'd3, 2'd3, 4'h0, 4'h0, 4'h0, 1'b0);
    run_cmd("r1r2_clr", F_OR, 2'd0, 2'd1, 2'd2, 4'h0, 4'h0, 4'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Register-file front end for the 4-bit combinational ALU: accepts register-to-register commands over a valid/ready handshake, reads two operands from an internal 4x4-bit register file, drives the ALU's A/B/F inputs from registers, captures Y and writes it back. Sits between the command source (test controller or future microsequencer) and the ALU, which is instantiated outside this block and connected through the alu_* ports.

## Interface
- Parameters: none (widths fixed: data 4, registers 4, function 3).
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_f  in  3  ALU function code
- cmd_rd  in  2  destination register index
- cmd_rs1  in  2  operand A register index
- cmd_rs2  in  2  operand B register index
- alu_a  out  4  registered operand A to ALU
- alu_b  out  4  registered operand B to ALU
- alu_f  out  3  registered function to ALU
- alu_y  in  4  ALU result (combinational from alu_a/alu_b/alu_f)
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  4  result value written to rd
- res_err  out  1  qualifies res_valid: command rejected, no writeback
- res_zero  out  1  (only with ALU_SEQ_ZERO_FLAG_EN) res_data == 0

## Operation
- Function codes: 000 AND, 001 OR, 010 ADD, 100 A&~B, 101 A|~B, 110 SUB, 111 SLT (unsigned, result 1/0). 011 is illegal.
- Arithmetic is modulo 16; no carry/overflow reported.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: cmd_ready=1. On cmd_valid: latch rd, load alu_a=rf[rs1], alu_b=rf[rs2], alu_f=cmd_f, go EXEC.
  - EXEC: cmd_ready=0. Capture alu_y; if alu_f != 011 write rf[rd]=alu_y, res_data=alu_y, res_err=0; if 011, no write, res_data=0, res_err=1. Go RESP.
  - RESP: res_valid=1, outputs stable. On res_ready go IDLE.
- rs1 == rs2 == rd is legal; operands read old value, rd receives new.
- Register file readable only through commands; all registers reset to 0.
- Reset at any state: return to IDLE, clear register file, drop in-flight command, no writeback.

## Timing
- Reset values: cmd_ready=1 (from first cycle after reset deasserts), res_valid=0, res_data=0, res_err=0, res_zero=0, alu_a=0, alu_b=0, alu_f=000, all rf=0.
- Accept at edge N (cmd_valid & cmd_ready); alu_* valid after N; writeback and res_valid rise at N+1.
- res_valid held until edge where res_ready=1; cmd_ready returns at that same edge, so next command accepted earliest one cycle later. Throughput: one command per 3 cycles with res_ready tied high.
- res_ready while res_valid=0 is ignored. cmd_valid outside IDLE is ignored (not queued).
- Command accepted after a writeback sees the updated register.

## Configuration
- ALU_SEQ_ZERO_FLAG_EN defined: res_zero port exists, registered with res_data in EXEC, equals (alu_y == 0) for legal ops, 0 on error.
- Undefined: res_zero port absent; all other behaviour identical.

## Structure
- Shared package alu_seq_pkg: function-code localparams (F_AND, F_OR, F_ADD, F_ANDN, F_ORN, F_SUB, F_SLT, F_ILLEGAL=3'b011), state enum type, DATA_W=4, REG_N=4.
- One natural sub-module: alu_seq_regfile (4x4, two async read ports, one sync write port, sync reset). FSM and operand registers stay in top.

## Test plan
- After reset, command ADD rd=0 rs1=1 rs2=2 -> res_data=0, res_err=0; alu_a/alu_b=0 during EXEC.
- Build values: preload via ORN rd=1 rs1=0 rs2=0 (r1=1111), SUB rd=2 rs1=0 rs2=1 (r2=0001); then ADD rd=3 rs1=1 rs2=2 -> res_data=0000 (wrap), zero flag 1 if enabled.
- SLT rd=0 rs1=2 rs2=1 (1<15) -> res_data=0001; SLT rd=0 rs1=1 rs2=2 -> 0000.
- Illegal cmd_f=011 rd=1 -> res_err=1, res_data=0; subsequent OR rd=0 rs1=1 rs2=1 returns 1111 (r1 unmodified).
- Hold res_ready=0 for 5 cycles with cmd_valid=1 -> res_valid/res_data stable, cmd_ready=0, no second accept; release -> one accept next IDLE cycle.
- Assert reset during EXEC after SUB targeting r3 -> r3 reads 0 afterward, res_valid=0, cmd_ready=1.
